// File: rtl/clk_ratio_meter_if.sv
`default_nettype none
// ============================================================================
//  Module   : clk_ratio_meter_if
//  Purpose  : Bundles the control, input and result signals of
//             clk_ratio_meter.
//  Signals  : en        - measurement enable (master -> slave)
//             sig_in    - divided clock under test (master -> slave)
//             ratio_out - last completed ratio, U(CNT_W-FRAC_BITS).FRAC_BITS
//             ratio_vld - one-cycle pulse when ratio_out updates
//             timeout   - sticky missing-edge flag
//             overflow  - sticky cycle-counter saturation flag
//  Modports : master (environment side), slave (meter side)
//  Revision : 1.0 - initial release
// ============================================================================
interface clk_ratio_meter_if #(
  parameter int CNT_W = 24
) ();
  logic             en;
  logic             sig_in;
  logic [CNT_W-1:0] ratio_out;
  logic             ratio_vld;
  logic             timeout;
  logic             overflow;

  modport master (
    output en, sig_in,
    input  ratio_out, ratio_vld, timeout, overflow
  );

  modport slave (
    input  en, sig_in,
    output ratio_out, ratio_vld, timeout, overflow
  );
endinterface
`default_nettype wire

// File: rtl/clk_ratio_meter.sv
`default_nettype none
// ============================================================================
//  Module   : clk_ratio_meter
//  Purpose  : Measures the period of a slow divided clock (sig_in) in clk_in
//             cycles, summed over 2^FRAC_BITS periods, giving the divide
//             ratio as unsigned fixed point without a divider.
//  Ports    : clk_in - measurement clock, all logic on posedge
//             rst_n  - asynchronous active-low reset
//             bus    - clk_ratio_meter_if.slave (en, sig_in in;
//                      ratio_out, ratio_vld, timeout, overflow out)
//  Params   : FRAC_BITS - window of 2^FRAC_BITS periods / fraction bits
//             CNT_W     - cycle counter and ratio_out width (must equal the
//                         interface CNT_W)
//             TIMEOUT   - max clk_in cycles between sig_in rising edges
//  Revision : 1.0 - initial release
// ============================================================================
module clk_ratio_meter #(
  parameter int FRAC_BITS = 8,
  parameter int CNT_W     = 24,
  parameter int TIMEOUT   = 65535
) (
  input wire               clk_in,
  input wire               rst_n,
  clk_ratio_meter_if.slave bus
);

  localparam int                  c_GAP_W     = $clog2(TIMEOUT + 1);
  localparam logic [FRAC_BITS-1:0] c_PER_LAST = '1;
  localparam logic [CNT_W-1:0]    c_CYC_MAX   = '1;
  // Gap counter holds d at d cycles after a rise, so hitting TIMEOUT-1
  // raises the flag exactly TIMEOUT cycles after the last rise.
  localparam logic [c_GAP_W-1:0]  c_GAP_LIMIT = c_GAP_W'(TIMEOUT - 1);
  localparam logic [c_GAP_W-1:0]  c_GAP_ONE   = c_GAP_W'(1);
  localparam logic [CNT_W-1:0]    c_CYC_ONE   = CNT_W'(1);
  localparam logic [FRAC_BITS-1:0] c_PER_ONE  = FRAC_BITS'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_MEAS = 2'd2
  } state_t;

  state_t               r_state, w_state_nxt;
  logic                 r_s1, r_s2, r_s3;
  logic [CNT_W-1:0]     r_cyc_cnt, w_cyc_nxt;
  logic [FRAC_BITS-1:0] r_per_cnt, w_per_nxt;
  logic [c_GAP_W-1:0]   r_gap_cnt, w_gap_nxt;
  logic [CNT_W-1:0]     r_ratio, w_ratio_nxt;
  logic                 r_vld, w_vld_nxt;
  logic                 r_timeout, w_timeout_nxt;
  logic                 r_overflow, w_overflow_nxt;
  logic                 w_rise;
  logic                 w_gap_hit;
  logic                 w_close;

  // Fixed three-flop latency for every edge, so no bias on the period sum.
  assign w_rise    = r_s2 & ~r_s3;
  assign w_gap_hit = (r_gap_cnt == c_GAP_LIMIT) && !w_rise;
  assign w_close   = w_rise && (r_per_cnt == c_PER_LAST);

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_s1       <= 1'b0;
      r_s2       <= 1'b0;
      r_s3       <= 1'b0;
      r_cyc_cnt  <= '0;
      r_per_cnt  <= '0;
      r_gap_cnt  <= '0;
      r_ratio    <= '0;
      r_vld      <= 1'b0;
      r_timeout  <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_s1       <= bus.sig_in;
      r_s2       <= r_s1;
      r_s3       <= r_s2;
      r_cyc_cnt  <= w_cyc_nxt;
      r_per_cnt  <= w_per_nxt;
      r_gap_cnt  <= w_gap_nxt;
      r_ratio    <= w_ratio_nxt;
      r_vld      <= w_vld_nxt;
      r_timeout  <= w_timeout_nxt;
      r_overflow <= w_overflow_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cyc_nxt      = r_cyc_cnt;
    w_per_nxt      = r_per_cnt;
    w_gap_nxt      = r_gap_cnt;
    w_ratio_nxt    = r_ratio;
    w_vld_nxt      = 1'b0;
    w_timeout_nxt  = r_timeout;
    w_overflow_nxt = r_overflow;

    if (!bus.en) begin
      // Disable overrides everything; the last result is kept.
      w_state_nxt    = S_IDLE;
      w_cyc_nxt      = '0;
      w_per_nxt      = '0;
      w_gap_nxt      = '0;
      w_timeout_nxt  = 1'b0;
      w_overflow_nxt = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt = S_ARM;
          w_gap_nxt   = '0;
        end

        S_ARM: begin
          if (w_rise) begin
            w_state_nxt = S_MEAS;
            w_cyc_nxt   = c_CYC_ONE;
            w_per_nxt   = '0;
            w_gap_nxt   = c_GAP_ONE;
          end else if (w_gap_hit) begin
            w_timeout_nxt = 1'b1;
            w_gap_nxt     = '0;
          end else begin
            w_gap_nxt = r_gap_cnt + c_GAP_ONE;
          end
        end

        S_MEAS: begin
          if (w_close) begin
            // Closing edge reports and opens the next window at once.
            w_ratio_nxt    = r_cyc_cnt;
            w_vld_nxt      = 1'b1;
            w_timeout_nxt  = 1'b0;
            w_overflow_nxt = 1'b0;
            w_cyc_nxt      = c_CYC_ONE;
            w_per_nxt      = '0;
            w_gap_nxt      = c_GAP_ONE;
          end else if (w_gap_hit) begin
            w_timeout_nxt = 1'b1;
            w_state_nxt   = S_ARM;
            w_cyc_nxt     = '0;
            w_per_nxt     = '0;
            w_gap_nxt     = '0;
          end else if (r_cyc_cnt == c_CYC_MAX) begin
            // Saturate instead of wrapping; the partial window is dropped.
            w_overflow_nxt = 1'b1;
            w_state_nxt    = S_ARM;
            w_cyc_nxt      = '0;
            w_per_nxt      = '0;
            w_gap_nxt      = w_rise ? c_GAP_ONE : r_gap_cnt + c_GAP_ONE;
          end else begin
            w_cyc_nxt = r_cyc_cnt + c_CYC_ONE;
            if (w_rise) begin
              w_per_nxt = r_per_cnt + c_PER_ONE;
              w_gap_nxt = c_GAP_ONE;
            end else begin
              w_gap_nxt = r_gap_cnt + c_GAP_ONE;
            end
          end
        end

        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  assign bus.ratio_out = r_ratio;
  assign bus.ratio_vld = r_vld;
  assign bus.timeout   = r_timeout;
  assign bus.overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_clk_ratio_meter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_clk_ratio_meter
//  Purpose  : Self-checking bench for clk_ratio_meter. Expected window sums
//             are queued as sig_in periods are driven and compared when
//             ratio_vld pulses. A second instance (CNT_W=12) covers
//             counter saturation.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_clk_ratio_meter;

  localparam int c_TIMEOUT = 3000;

  logic clk_in;
  logic rst_n;

  clk_ratio_meter_if #(.CNT_W(24)) ifm ();
  clk_ratio_meter_if #(.CNT_W(12)) ifo ();

  assign ifo.sig_in = ifm.sig_in;

  clk_ratio_meter #(.FRAC_BITS(8), .CNT_W(24), .TIMEOUT(c_TIMEOUT)) u_dut (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .bus    (ifm.slave)
  );

  clk_ratio_meter #(.FRAC_BITS(8), .CNT_W(12), .TIMEOUT(65535)) u_dut_ovf (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .bus    (ifo.slave)
  );

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          last_rise_cyc = 0;
  int          vld_count = 0;
  int          last_vld_cyc = 0;
  int          prev_vld_cyc = 0;
  logic [23:0] last_vld_val = '0;
  logic [23:0] prev_vld_val = '0;
  logic [23:0] sb[$];

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  initial begin
    forever begin
      @(posedge clk_in);
      cyc = cyc + 1;
    end
  end

  // Scoreboard consumer.
  initial begin
    logic [23:0] exp_val;
    forever begin
      @(negedge clk_in);
      if (rst_n && ifm.ratio_vld) begin
        vld_count    = vld_count + 1;
        prev_vld_cyc = last_vld_cyc;
        last_vld_cyc = cyc;
        prev_vld_val = last_vld_val;
        last_vld_val = ifm.ratio_out;
        checks = checks + 1;
        if (sb.size() == 0) begin
          errors = errors + 1;
          $display("FAIL unexpected_vld: ratio_out=%h with no result expected (cycle %0d)",
                   ifm.ratio_out, cyc);
        end else begin
          exp_val = sb.pop_front();
          if (ifm.ratio_out !== exp_val) begin
            errors = errors + 1;
            $display("FAIL ratio_out: got %h expected %h (cycle %0d)",
                     ifm.ratio_out, exp_val, cyc);
          end
        end
      end
    end
  end

  // Must be entered at a negedge; drives one rising edge and p cycles.
  task automatic drive_period(input int p);
    ifm.sig_in    = 1'b1;
    last_rise_cyc = cyc;
    repeat (p / 2) @(negedge clk_in);
    ifm.sig_in = 1'b0;
    repeat (p - p / 2) @(negedge clk_in);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk_in);
    repeat (3) @(negedge clk_in);
  endtask

  task automatic restart_en();
    ifm.en = 1'b0;
    repeat (2) @(negedge clk_in);
    ifm.en = 1'b1;
    repeat (3) @(negedge clk_in);
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    ifm.en     = 1'b0;
    ifo.en     = 1'b0;
    ifm.sig_in = 1'b0;
    repeat (3) @(negedge clk_in);
    checks = checks + 4;
    if (ifm.ratio_out !== 24'h0) begin
      errors++; $display("FAIL reset_ratio: got %h expected 000000", ifm.ratio_out);
    end
    if (ifm.ratio_vld !== 1'b0) begin
      errors++; $display("FAIL reset_vld: got %b expected 0", ifm.ratio_vld);
    end
    if (ifm.timeout !== 1'b0) begin
      errors++; $display("FAIL reset_timeout: got %b expected 0", ifm.timeout);
    end
    if (ifo.overflow !== 1'b0) begin
      errors++; $display("FAIL reset_overflow: got %b expected 0", ifo.overflow);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk_in);
  endtask

  task automatic test_period4();
    restart_en();
    sb.push_back(24'h000400);
    sb.push_back(24'h000400);
    for (int i = 0; i < 513; i++) drive_period(4);
    wait_drain();
    checks = checks + 2;
    if (sb.size() != 0) begin
      errors++; $display("FAIL p4_drain: %0d results still pending, expected 0", sb.size());
    end
    if (last_vld_cyc - prev_vld_cyc != 1024) begin
      errors++; $display("FAIL p4_spacing: vld spacing %0d expected 1024",
                         last_vld_cyc - prev_vld_cyc);
    end
  endtask

  task automatic test_fractional();
    int acc;
    int p;
    int sum;
    int per[$];
    int diff;
    restart_en();
    acc = 0;
    for (int i = 0; i < 513; i++) begin
      acc = acc + 66;
      if (acc >= 100) begin
        p = 9; acc = acc - 100;
      end else begin
        p = 8;
      end
      per.push_back(p);
    end
    for (int w = 0; w < 2; w++) begin
      sum = 0;
      for (int i = 0; i < 256; i++) sum = sum + per[w * 256 + i];
      sb.push_back(24'(sum));
    end
    for (int i = 0; i < 513; i++) drive_period(per[i]);
    wait_drain();
    diff = int'(last_vld_val) - int'(prev_vld_val);
    checks = checks + 3;
    if (sb.size() != 0) begin
      errors++; $display("FAIL frac_drain: %0d results still pending, expected 0", sb.size());
    end
    if (ifm.ratio_out !== 24'h0008A8 && ifm.ratio_out !== 24'h0008A9) begin
      errors++; $display("FAIL frac_range: got %h expected 0008a8 or 0008a9", ifm.ratio_out);
    end
    if (diff > 1 || diff < -1) begin
      errors++; $display("FAIL frac_step: windows differ by %0d expected <=1", diff);
    end
  endtask

  task automatic test_timeout();
    bit seen;
    int to_cyc;
    int vld_before;
    restart_en();
    vld_before = vld_count;
    for (int i = 0; i < 100; i++) drive_period(10);
    seen = 1'b0;
    to_cyc = 0;
    for (int i = 0; i < c_TIMEOUT + 50 && !seen; i++) begin
      @(negedge clk_in);
      if (ifm.timeout === 1'b1) begin
        seen = 1'b1; to_cyc = cyc;
      end
    end
    checks = checks + 3;
    if (!seen) begin
      errors++; $display("FAIL timeout_set: timeout never rose, expected 1");
    end else if (to_cyc - last_rise_cyc != c_TIMEOUT + 2) begin
      errors++; $display("FAIL timeout_time: rose %0d cycles after rise drive, expected %0d",
                         to_cyc - last_rise_cyc, c_TIMEOUT + 2);
    end
    if (vld_count != vld_before) begin
      errors++; $display("FAIL timeout_novld: %0d vld pulses, expected 0", vld_count - vld_before);
    end
    sb.push_back(24'h000A00);
    for (int i = 0; i < 257; i++) begin
      drive_period(10);
      if (i == 128) begin
        checks++;
        if (ifm.timeout !== 1'b1) begin
          errors++; $display("FAIL timeout_sticky: got %b expected 1", ifm.timeout);
        end
      end
    end
    wait_drain();
    checks = checks + 2;
    if (ifm.timeout !== 1'b0) begin
      errors++; $display("FAIL timeout_clear: got %b expected 0", ifm.timeout);
    end
    if (ifm.ratio_out !== 24'h000A00) begin
      errors++; $display("FAIL timeout_ratio: got %h expected 000a00", ifm.ratio_out);
    end
  endtask

  task automatic test_overflow();
    int k0;
    bit ovf_seen;
    int ovf_cyc;
    int ovf_vld;
    ifm.en = 1'b0;
    ifo.en = 1'b1;
    repeat (3) @(negedge clk_in);
    k0 = cyc;
    ovf_seen = 1'b0;
    ovf_cyc = 0;
    ovf_vld = 0;
    fork
      begin
        for (int i = 0; i < 220; i++) drive_period(20);
      end
      begin
        for (int i = 0; i < 4400; i++) begin
          @(negedge clk_in);
          if (ifo.ratio_vld === 1'b1) ovf_vld++;
          if (ifo.overflow === 1'b1 && !ovf_seen) begin
            ovf_seen = 1'b1; ovf_cyc = cyc;
          end
        end
      end
    join
    checks = checks + 3;
    if (!ovf_seen) begin
      errors++; $display("FAIL ovf_set: overflow never rose, expected 1");
    end else if (ovf_cyc - k0 != 4098) begin
      errors++; $display("FAIL ovf_time: rose %0d cycles after first rise, expected 4098",
                         ovf_cyc - k0);
    end
    if (ovf_vld != 0) begin
      errors++; $display("FAIL ovf_novld: %0d vld pulses, expected 0", ovf_vld);
    end
    if (ifo.ratio_out !== 12'h000) begin
      errors++; $display("FAIL ovf_ratio: got %h expected 000", ifo.ratio_out);
    end
    ifo.en = 1'b0;
    repeat (2) @(negedge clk_in);
    checks++;
    if (ifo.overflow !== 1'b0) begin
      errors++; $display("FAIL ovf_clear: got %b expected 0", ifo.overflow);
    end
  endtask

  task automatic test_enable_abort();
    int vld_before;
    ifm.en = 1'b1;
    repeat (3) @(negedge clk_in);
    for (int i = 0; i < 101; i++) drive_period(10);
    ifm.en = 1'b0;
    repeat (3) @(negedge clk_in);
    checks = checks + 2;
    if (ifm.ratio_out !== 24'h000A00) begin
      errors++; $display("FAIL en_hold: got %h expected 000a00", ifm.ratio_out);
    end
    if (ifm.timeout !== 1'b0 || ifm.overflow !== 1'b0) begin
      errors++; $display("FAIL en_flags: timeout=%b overflow=%b expected 0 0",
                         ifm.timeout, ifm.overflow);
    end
    ifm.en = 1'b1;
    repeat (3) @(negedge clk_in);
    vld_before = vld_count;
    sb.push_back(24'h000600);
    for (int i = 0; i < 256; i++) drive_period(6);
    checks = checks + 2;
    if (vld_count != vld_before) begin
      errors++; $display("FAIL en_early_vld: %0d vld before edge 257, expected 0",
                         vld_count - vld_before);
    end
    if (ifm.ratio_out !== 24'h000A00) begin
      errors++; $display("FAIL en_hold2: got %h expected 000a00", ifm.ratio_out);
    end
    drive_period(6);
    wait_drain();
    checks++;
    if (vld_count != vld_before + 1) begin
      errors++; $display("FAIL en_vld: %0d vld after edge 257, expected 1", vld_count - vld_before);
    end
  endtask

  task automatic test_reset_midwindow();
    for (int i = 0; i < 50; i++) drive_period(6);
    @(posedge clk_in);
    #3 rst_n = 1'b0;
    #1;
    checks = checks + 2;
    if (ifm.ratio_out !== 24'h0) begin
      errors++; $display("FAIL rst_ratio: got %h expected 000000", ifm.ratio_out);
    end
    if (ifm.ratio_vld !== 1'b0 || ifm.timeout !== 1'b0 || ifm.overflow !== 1'b0) begin
      errors++; $display("FAIL rst_flags: vld=%b timeout=%b overflow=%b expected 0 0 0",
                         ifm.ratio_vld, ifm.timeout, ifm.overflow);
    end
    repeat (2) @(negedge clk_in);
    rst_n = 1'b1;
    repeat (3) @(negedge clk_in);
    sb.push_back(24'h000500);
    for (int i = 0; i < 257; i++) drive_period(5);
    wait_drain();
    checks = checks + 2;
    if (sb.size() != 0) begin
      errors++; $display("FAIL rst_drain: %0d results still pending, expected 0", sb.size());
    end
    if (ifm.ratio_out !== 24'h000500) begin
      errors++; $display("FAIL rst_restart: got %h expected 000500", ifm.ratio_out);
    end
  endtask

  initial begin
    test_reset();
    test_period4();
    test_fractional();
    test_timeout();
    test_overflow();
    test_enable_abort();
    test_reset_midwindow();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
